irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised interrupt controller that replaces the fixed 4-line IRQ latch and priority encoder inside the CPU core.
- Accepts NUM_IRQ sources, each with per-line enable and edge/level mode, and arbitrates them by fixed priority (highest index wins).
- Presents one request plus a vector address to the CPU, and tracks the in-service interrupt until end-of-interrupt.
- Configured and inspected through a Wishbone-style slave register port on the same bus as memory.

Parameters:
- NUM_IRQ, 4, number of interrupt sources; legal range 1..31.
- VEC_BASE, 32'h00000000, base address of the vector table.

Ports:
- clk  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- irq_i  in  NUM_IRQ  interrupt source lines, synchronous to clk.
- stb_i  in  1  bus strobe.
- we_i  in  1  bus write enable.
- adr_i  in  2  register word address.
- dat_i  in  32  bus write data.
- dat_o  out  32  bus read data.
- ack_o  out  1  bus acknowledge.
- irq_req_o  out  1  interrupt request to CPU.
- irq_vec_o  out  32  vector address for the current request.
- irq_ack_i  in  1  CPU has taken the request (vector fetch accepted).
- irq_eoi_i  in  1  CPU end-of-interrupt pulse (RTI executed).

Behaviour:
- Clock and reset: one clock, clk. rst_i is synchronous and active-high.
- Reset values: pending=0, enable=0, mode=0, irq_prev=0, state=IDLE, irq_req_o=0, irq_vec_o=0, ack_o=0, dat_o=0, active_id=0.
- Registers (adr_i):
  - 0 PENDING: read; write-1-to-clear, affects edge-mode bits only.
  - 1 ENABLE: read/write, bits [NUM_IRQ-1:0].
  - 2 MODE: read/write; 1=edge (rising), 0=level.
  - 3 STATUS: read-only. bit31=in-service, bit30=irq_req_o, bits[4:0]=active_id. Writes are ignored.
  - Unused upper bits read 0.
- Bus handshake:
  - ack_o rises the cycle after stb_i=1 while ack_o=0, and stays high one cycle only.
  - A write takes effect on the ack cycle; dat_o is valid on the ack cycle.
  - Back-to-back held stb_i therefore gives ack every other cycle.
- Pending update (every cycle):
  - Edge-mode bit: set when irq_i=1 and irq_prev=0. Cleared by write-1-clear or by irq_ack_i for the active line.
  - Level-mode bit: follows the registered irq_i.
  - Set wins over clear in the same cycle.
- Arbitration:
  - eligible = pending & enable.
  - winner = highest set index.
  - vector = VEC_BASE + ((NUM_IRQ - winner) << 2). With NUM_IRQ=4: irq3->0x4, irq0->0x10. Address 0 stays the reset vector.
- State machine:
  - IDLE: if eligible != 0, latch winner into active_id and its vector into irq_vec_o, assert irq_req_o, go to REQ.
  - REQ: irq_req_o and irq_vec_o are held stable, even if the source drops or a higher line arrives (no withdrawal). On irq_ack_i: drop irq_req_o, clear the edge pending bit of active_id, go to SVC.
  - SVC: no new requests (no nesting). On irq_eoi_i, go to IDLE. Re-arbitration happens the following cycle, so the minimum gap between EOI and the next irq_req_o is 1 cycle.
- Ignored events: irq_ack_i outside REQ; irq_eoi_i outside SVC.
- Simultaneous irq_ack_i and irq_eoi_i: only the one matching the current state is acted on.
- Disabling the active line in REQ or SVC does not abort the transaction.
- Level-mode source still high at EOI: re-requests after the 1-cycle gap.
- rst_i asserted mid-transaction returns to IDLE with all state cleared in the same edge. No request survives reset.
- Request latency: edge on irq_i at cycle N (enabled) -> pending at N+1 -> irq_req_o=1 at N+2.

Test Plan:
- Reset, then read all 4 registers -> each returns 0; irq_req_o=0, irq_vec_o=0.
- NUM_IRQ=4; write ENABLE=0xF, MODE=0xF; pulse irq_i[1] for one cycle -> irq_req_o=1 two cycles later, irq_vec_o=0xC, STATUS=0x40000001. Pulse irq_ack_i -> req=0, PENDING=0, STATUS bit31=1. Pulse irq_eoi_i -> STATUS=0.
- Pulse irq_i[0] and irq_i[3] in the same cycle -> vector 0x4 first. After ack and EOI -> vector 0x10 follows one cycle later.
- Level mode: ENABLE=0x4, MODE=0; hold irq_i[2]=1 through ack and EOI -> a second request with vector 0x8 appears 1 cycle after EOI. Drop irq_i[2] before EOI -> no second request.
- In REQ with irq_i[1] active, raise irq_i[3] -> vector stays 0xC until ack. Write PENDING=0x8 in the same cycle a new irq_i[3] edge is detected -> bit 3 stays set.
- Assert rst_i while in SVC -> next cycle: state IDLE, ENABLE=0, irq_req_o=0. A subsequent irq_i[2] edge produces no request until re-enabled.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Register-port bus between a bus master and the interrupt controller.
// Signal names are seen from the controller, which is the slave.
interface irq_ctrl_if;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (output stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
    modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: per-line enable and edge/level mode,
// one outstanding request with a vector, held in service until EOI.
module irq_ctrl #(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    irq_ctrl_if.slave          bus,
    output logic               irq_req_o,
    output logic [31:0]        irq_vec_o,
    input  logic               irq_ack_i,
    input  logic               irq_eoi_i
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic               req_q;
    logic [31:0]        vec_q;
    logic [4:0]         active_q;
    logic               ack_q;
    logic [31:0]        dat_q;

    logic [NUM_IRQ-1:0] eligible, w1c, ack_clr, edge_set;
    logic [4:0]         winner;
    logic [31:0]        vector, rdata;
    logic               wr_en;

    always_comb begin
        eligible = pending_q & enable_q;
        winner   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) winner = 5'(i);
        end
        // Highest line gets the lowest slot so address VEC_BASE stays the reset vector.
        vector = VEC_BASE + ((32'(NUM_IRQ) - 32'(winner)) << 2);

        wr_en    = bus.stb_i & bus.we_i & ack_q;
        w1c      = (wr_en && bus.adr_i == 2'd0) ? bus.dat_i[NUM_IRQ-1:0] : '0;
        ack_clr  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (state_q == REQ && irq_ack_i && active_q == 5'(i)) ack_clr[i] = 1'b1;
        end
        edge_set  = irq_i & ~irq_prev_q;
        pending_d = (mode_q & ((pending_q & ~(w1c | ack_clr)) | edge_set))
                  | (~mode_q & irq_i);

        rdata = '0;
        case (bus.adr_i)
            2'd0: rdata = {{(32-NUM_IRQ){1'b0}}, pending_q};
            2'd1: rdata = {{(32-NUM_IRQ){1'b0}}, enable_q};
            2'd2: rdata = {{(32-NUM_IRQ){1'b0}}, mode_q};
            2'd3: rdata = {state_q == SVC, req_q, 25'd0, active_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            irq_prev_q <= '0;
            req_q      <= 1'b0;
            vec_q      <= '0;
            active_q   <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= pending_d;
            ack_q      <= bus.stb_i & ~ack_q;
            dat_q      <= (bus.stb_i & ~ack_q) ? rdata : '0;
            if (wr_en && bus.adr_i == 2'd1) enable_q <= bus.dat_i[NUM_IRQ-1:0];
            if (wr_en && bus.adr_i == 2'd2) mode_q   <= bus.dat_i[NUM_IRQ-1:0];

            case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        active_q <= winner;
                        vec_q    <= vector;
                        req_q    <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= SVC;
                    end
                end
                SVC: begin
                    if (irq_eoi_i) begin
                        active_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_req_o = req_q;
    assign irq_vec_o = vec_q;
    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with NUM_IRQ=4, VEC_BASE=0.
module tb_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] irq_i;
    logic       irq_req_o;
    logic [31:0] irq_vec_o;
    logic       irq_ack_i;
    logic       irq_eoi_i;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [31:0] rd;

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_IRQ(4), .VEC_BASE(32'h0)) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .irq_i     (irq_i),
        .bus       (bus),
        .irq_req_o (irq_req_o),
        .irq_vec_o (irq_vec_o),
        .irq_ack_i (irq_ack_i),
        .irq_eoi_i (irq_eoi_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] adr, input logic [31:0] data);
        bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = adr; bus.dat_i = data;
        tick();
        tick();
        bus.stb_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] adr, output logic [31:0] data);
        bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = adr;
        tick();
        data = bus.dat_o;
        tick();
        bus.stb_i = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi_i = 1'b1; tick(); irq_eoi_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; irq_i = '0; irq_ack_i = 1'b0; irq_eoi_i = 1'b0;
        bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;
        tick(); tick();
        rst_i = 1'b0;

        // reset state
        chk("rst_req", 32'(irq_req_o), 32'd0);
        chk("rst_vec", irq_vec_o, 32'h0);
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_dat", bus.dat_o, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            chk($sformatf("rst_reg%0d", a), rd, 32'h0);
        end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd);
        chk("status_ro", rd, 32'h0);

        // single edge on line 1
        bus_write(2'd1, 32'hF);
        bus_write(2'd2, 32'hF);
        bus_read(2'd1, rd);
        chk("enable_rd", rd, 32'hF);
        irq_i = 4'b0010; tick(); irq_i = '0;
        chk("lat_n1_req", 32'(irq_req_o), 32'd0);
        tick();
        chk("lat_n2_req", 32'(irq_req_o), 32'd1);
        chk("irq1_vec", irq_vec_o, 32'hC);
        bus_read(2'd3, rd);
        chk("irq1_status_req", rd, 32'h4000_0001);
        pulse_ack();
        chk("irq1_ack_req", 32'(irq_req_o), 32'd0);
        bus_read(2'd0, rd);
        chk("irq1_pend_clr", rd, 32'h0);
        bus_read(2'd3, rd);
        chk("irq1_status_svc", rd, 32'h8000_0001);
        pulse_eoi();
        bus_read(2'd3, rd);
        chk("irq1_status_eoi", rd, 32'h0);

        // simultaneous lines 0 and 3
        irq_i = 4'b1001; tick(); irq_i = '0; tick();
        chk("pri_req", 32'(irq_req_o), 32'd1);
        chk("pri_vec3", irq_vec_o, 32'h4);
        pulse_ack();
        pulse_eoi();
        chk("pri_gap", 32'(irq_req_o), 32'd0);
        tick();
        chk("pri_req0", 32'(irq_req_o), 32'd1);
        chk("pri_vec0", irq_vec_o, 32'h10);
        pulse_ack();
        pulse_eoi();

        // level mode on line 2
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'h0);
        irq_i = 4'b0100; tick(); tick();
        chk("lvl_req", 32'(irq_req_o), 32'd1);
        chk("lvl_vec", irq_vec_o, 32'h8);
        pulse_ack();
        chk("lvl_ack_req", 32'(irq_req_o), 32'd0);
        bus_read(2'd3, rd);
        chk("lvl_status", rd, 32'h8000_0002);
        pulse_eoi();
        chk("lvl_gap", 32'(irq_req_o), 32'd0);
        tick();
        chk("lvl_rereq", 32'(irq_req_o), 32'd1);
        chk("lvl_rereq_vec", irq_vec_o, 32'h8);
        pulse_ack();
        irq_i = '0; tick();
        pulse_eoi();
        tick();
        chk("lvl_drop_req_a", 32'(irq_req_o), 32'd0);
        tick();
        chk("lvl_drop_req_b", 32'(irq_req_o), 32'd0);

        // no withdrawal in REQ; write-1-clear vs. simultaneous edge
        bus_write(2'd2, 32'hF);
        bus_write(2'd1, 32'hF);
        irq_i = 4'b0010; tick(); irq_i = '0; tick();
        chk("hold_vec_a", irq_vec_o, 32'hC);
        irq_i = 4'b1000; tick(); irq_i = '0; tick();
        chk("hold_req", 32'(irq_req_o), 32'd1);
        chk("hold_vec_b", irq_vec_o, 32'hC);
        bus_read(2'd0, rd);
        chk("hold_pend", rd, 32'hA);
        chk("hold_vec_c", irq_vec_o, 32'hC);
        pulse_ack();
        bus_read(2'd0, rd);
        chk("svc_pend", rd, 32'h8);
        bus_write(2'd0, 32'h8);
        bus_read(2'd0, rd);
        chk("w1c_pend", rd, 32'h0);
        bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 2'd0; bus.dat_i = 32'h8;
        tick();
        irq_i = 4'b1000;
        tick();
        irq_i = '0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus_read(2'd0, rd);
        chk("set_wins", rd, 32'h8);
        pulse_eoi();
        tick();
        chk("irq3_req", 32'(irq_req_o), 32'd1);
        chk("irq3_vec", irq_vec_o, 32'h4);
        pulse_ack();
        bus_read(2'd3, rd);
        chk("irq3_status", rd, 32'h8000_0003);

        // reset while in service
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("mid_rst_req", 32'(irq_req_o), 32'd0);
        chk("mid_rst_vec", irq_vec_o, 32'h0);
        bus_read(2'd1, rd);
        chk("mid_rst_enable", rd, 32'h0);
        bus_read(2'd3, rd);
        chk("mid_rst_status", rd, 32'h0);
        irq_i = 4'b0100; tick(); irq_i = '0; tick(); tick();
        chk("dis_no_req", 32'(irq_req_o), 32'd0);
        bus_write(2'd2, 32'h4);
        bus_write(2'd1, 32'h4);
        irq_i = 4'b0100; tick(); irq_i = '0; tick();
        chk("reen_req", 32'(irq_req_o), 32'd1);
        chk("reen_vec", irq_vec_o, 32'h8);

        // EOI ignored in REQ; simultaneous ack+EOI in REQ acts on ack only
        pulse_eoi();
        chk("eoi_in_req", 32'(irq_req_o), 32'd1);
        irq_ack_i = 1'b1; irq_eoi_i = 1'b1; tick();
        irq_ack_i = 1'b0; irq_eoi_i = 1'b0;
        chk("both_req", 32'(irq_req_o), 32'd0);
        bus_read(2'd3, rd);
        chk("both_status", rd, 32'h8000_0002);
        pulse_ack();
        bus_read(2'd3, rd);
        chk("ack_in_svc", rd, 32'h8000_0002);
        pulse_eoi();
        bus_read(2'd3, rd);
        chk("final_status", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
